// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Brief    : Multi-cycle ALU with a ready/valid handshake, registered flags
//            and an optional shift-add multiplier.
// Revision : 1.0
// ============================================================================
module alu_mc #(
   parameter int WIDTH  = 8,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_n,
   output logic             flag_v
);

   localparam int MSB   = WIDTH - 1;
   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [3:0] c_op_add = 4'd0;
   localparam logic [3:0] c_op_sub = 4'd1;
   localparam logic [3:0] c_op_and = 4'd2;
   localparam logic [3:0] c_op_or  = 4'd3;
   localparam logic [3:0] c_op_xor = 4'd4;
   localparam logic [3:0] c_op_not = 4'd5;
   localparam logic [3:0] c_op_shl = 4'd6;
   localparam logic [3:0] c_op_shr = 4'd7;
   localparam logic [3:0] c_op_adc = 4'd8;
   localparam logic [3:0] c_op_sbb = 4'd9;
   localparam logic [3:0] c_op_rol = 4'd10;
   localparam logic [3:0] c_op_ror = 4'd11;
   localparam logic [3:0] c_op_mul = 4'd12;
   localparam logic [3:0] c_op_cmp = 4'd13;

   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t r_state, w_next;

   logic [WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0] r_prod;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_is_mul;
   logic               w_mul_last;
   logic [WIDTH:0]     w_madd;
   logic [2*WIDTH-1:0] w_prod_next;

   logic               w_cin;
   logic [WIDTH:0]     w_sum, w_dif;
   logic               w_add_v, w_sub_v;
   logic [WIDTH-1:0]   w_res, w_zn;
   logic               w_c, w_v;

   assign in_ready   = (r_state == S_IDLE);
   assign out_valid  = (r_state == S_HOLD);
   assign w_is_mul   = (MUL_EN != 0) && (op == c_op_mul);
   assign w_mul_last = (r_cnt == c_cnt_last);

   // Upper half accumulates the multiplicand; lower half shifts out multiplier bits.
   assign w_madd      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
   assign w_prod_next = {w_madd, r_prod[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid) w_next = w_is_mul ? S_MUL : S_HOLD;
         S_MUL:   if (w_mul_last) w_next = S_HOLD;
         S_HOLD:  if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_cin   = (op == c_op_adc || op == c_op_sbb) ? flag_c : 1'b0;
      w_sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cin};
      w_dif   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, w_cin};
      w_add_v = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      w_sub_v = (a[MSB] != b[MSB]) && (w_dif[MSB] != a[MSB]);
      w_res   = '0;
      w_c     = 1'b0;
      w_v     = 1'b0;
      case (op)
         c_op_add, c_op_adc: begin w_res = w_sum[MSB:0]; w_c = w_sum[WIDTH]; w_v = w_add_v; end
         c_op_sub, c_op_sbb: begin w_res = w_dif[MSB:0]; w_c = w_dif[WIDTH]; w_v = w_sub_v; end
         c_op_cmp:           begin w_res = a;            w_c = w_dif[WIDTH]; w_v = w_sub_v; end
         c_op_and: w_res = a & b;
         c_op_or:  w_res = a | b;
         c_op_xor: w_res = a ^ b;
         c_op_not: w_res = ~a;
         c_op_shl: begin w_res = {a[MSB-1:0], 1'b0};   w_c = a[MSB]; end
         c_op_shr: begin w_res = {1'b0, a[MSB:1]};     w_c = a[0];   end
         c_op_rol: begin w_res = {a[MSB-1:0], a[MSB]}; w_c = a[MSB]; end
         c_op_ror: begin w_res = {a[0], a[MSB:1]};     w_c = a[0];   end
         default: ;
      endcase
      // CMP reports the difference in Z/N while passing a through as the result.
      w_zn = (op == c_op_cmp) ? w_dif[MSB:0] : w_res;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result    <= '0;
         result_hi <= '0;
         flag_z    <= 1'b0;
         flag_c    <= 1'b0;
         flag_n    <= 1'b0;
         flag_v    <= 1'b0;
         r_mcand   <= '0;
         r_prod    <= '0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  if (w_is_mul) begin
                     r_mcand <= a;
                     r_prod  <= {{WIDTH{1'b0}}, b};
                     r_cnt   <= '0;
                  end else begin
                     result    <= w_res;
                     result_hi <= '0;
                     flag_z    <= (w_zn == '0);
                     flag_n    <= w_zn[MSB];
                     flag_c    <= w_c;
                     flag_v    <= w_v;
                  end
               end
            end
            S_MUL: begin
               r_prod <= w_prod_next;
               r_cnt  <= r_cnt + CNT_W'(1);
               if (w_mul_last) begin
                  result    <= w_prod_next[WIDTH-1:0];
                  result_hi <= w_prod_next[2*WIDTH-1:WIDTH];
                  flag_z    <= (w_prod_next == '0);
                  flag_n    <= w_prod_next[2*WIDTH-1];
                  flag_c    <= (w_prod_next[2*WIDTH-1:WIDTH] != '0);
                  flag_v    <= (w_prod_next[2*WIDTH-1:WIDTH] != '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Brief    : Directed self-checking bench for alu_mc (WIDTH=8 and WIDTH=16).
// Revision : 1.0
// ============================================================================
module tb_alu_mc;

   logic        clk, rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [7:0]  a, b, result, result_hi;
   logic [3:0]  op;
   logic        flag_z, flag_c, flag_n, flag_v;
   logic [3:0]  flags8;

   logic        in_valid16, in_ready16, out_valid16, out_ready16;
   logic [15:0] a16, b16, result16, result_hi16;
   logic [3:0]  op16;
   logic        fz16, fc16, fn16, fv16;
   logic [3:0]  flags16;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] r;
      logic [3:0] f;
   } vec_t;

   assign flags8  = {flag_z, flag_c, flag_n, flag_v};
   assign flags16 = {fz16, fc16, fn16, fv16};

   alu_mc #(.WIDTH(8), .MUL_EN(1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .result_hi(result_hi),
      .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v)
   );

   alu_mc #(.WIDTH(16), .MUL_EN(1)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .op(op16), .out_valid(out_valid16), .out_ready(out_ready16),
      .result(result16), .result_hi(result_hi16),
      .flag_z(fz16), .flag_c(fc16), .flag_n(fn16), .flag_v(fv16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one 8-bit request at the current negedge; return at the negedge where out_valid is seen.
   task automatic run8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                       output int lat, output int ready_hi);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = ~x; b = ~y; op = 4'd14;
      lat = 0; ready_hi = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
         if (in_ready) ready_hi++;
      end
   endtask

   task automatic run16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                        output int lat);
      op16 = o; a16 = x; b16 = y; in_valid16 = 1'b1;
      @(posedge clk); #1;
      in_valid16 = 1'b0; a16 = ~x; b16 = ~y;
      lat = 0;
      while (lat < 60) begin
         @(negedge clk);
         lat++;
         if (out_valid16) break;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
      in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; op16 = '0;
      #2;
      n_checks++;
      if ({out_valid, result, result_hi, flags8} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got ov=%b res=%h hi=%h flags=%b required all zero",
                  out_valid, result, result_hi, flags8);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_ready: got ready=%b valid=%b required ready=1 valid=0", in_ready, out_valid);
      end
   endtask

   task automatic test_add_adc();
      int lat, rh;
      run8(4'd0, 8'hFF, 8'h01, lat, rh);
      n_checks++;
      if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d required 1", lat); end
      n_checks++;
      if ({result, result_hi, flags8} !== {8'h00, 8'h00, 4'b1100}) begin
         n_fail++;
         $display("FAIL add_ff_01: got res=%h hi=%h zcnv=%b required res=00 hi=00 zcnv=1100", result, result_hi, flags8);
      end
      @(negedge clk);
      run8(4'd8, 8'h00, 8'h00, lat, rh);
      n_checks++;
      if ({result, flags8} !== {8'h01, 4'b0000}) begin
         n_fail++;
         $display("FAIL adc_carry_in: got res=%h zcnv=%b required res=01 zcnv=0000", result, flags8);
      end
      @(negedge clk);
   endtask

   task automatic test_sub_cmp();
      int lat, rh;
      run8(4'd1, 8'h80, 8'h01, lat, rh);
      n_checks++;
      if ({result, flags8} !== {8'h7F, 4'b0001}) begin
         n_fail++;
         $display("FAIL sub_overflow: got res=%h zcnv=%b required res=7f zcnv=0001", result, flags8);
      end
      @(negedge clk);
      run8(4'd13, 8'h05, 8'h07, lat, rh);
      n_checks++;
      if ({result, flags8} !== {8'h05, 4'b0110}) begin
         n_fail++;
         $display("FAIL cmp_borrow: got res=%h zcnv=%b required res=05 zcnv=0110", result, flags8);
      end
      @(negedge clk);
   endtask

   task automatic test_ops();
      int lat, rh;
      vec_t v[13];
      // Order matters: SBB and ADC consume the carry left by the preceding op.
      v = '{
         '{4'd2,  8'hF0, 8'h3C, 8'h30, 4'b0000},
         '{4'd3,  8'hF0, 8'h0C, 8'hFC, 4'b0010},
         '{4'd4,  8'hAA, 8'hAA, 8'h00, 4'b1000},
         '{4'd5,  8'h0F, 8'h33, 8'hF0, 4'b0010},
         '{4'd6,  8'h81, 8'h00, 8'h02, 4'b0100},
         '{4'd9,  8'h10, 8'h05, 8'h0A, 4'b0000},
         '{4'd7,  8'h81, 8'h00, 8'h40, 4'b0100},
         '{4'd10, 8'h81, 8'h00, 8'h03, 4'b0100},
         '{4'd8,  8'h10, 8'h05, 8'h16, 4'b0000},
         '{4'd0,  8'h7F, 8'h01, 8'h80, 4'b0011},
         '{4'd14, 8'h55, 8'hAA, 8'h00, 4'b1000},
         '{4'd11, 8'h02, 8'h00, 8'h01, 4'b0000},
         '{4'd15, 8'hFF, 8'hFF, 8'h00, 4'b1000}
      };
      for (int i = 0; i < 13; i++) begin
         run8(v[i].op, v[i].a, v[i].b, lat, rh);
         n_checks++;
         if ({lat, result, result_hi, flags8} !== {32'd1, v[i].r, 8'h00, v[i].f}) begin
            n_fail++;
            $display("FAIL op%0d_vec%0d: got lat=%0d res=%h hi=%h zcnv=%b required lat=1 res=%h hi=00 zcnv=%b",
                     v[i].op, i, lat, result, result_hi, flags8, v[i].r, v[i].f);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_mul();
      int lat, rh;
      run8(4'd12, 8'hFF, 8'hFF, lat, rh);
      n_checks++;
      if (lat !== 9) begin n_fail++; $display("FAIL mul_latency: got %0d required 9", lat); end
      n_checks++;
      if (rh !== 0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mul_busy_ready: got %0d ready cycles (ready now %b) required 0", rh, in_ready);
      end
      n_checks++;
      if ({result, result_hi, flags8} !== {8'h01, 8'hFE, 4'b0111}) begin
         n_fail++;
         $display("FAIL mul_ff_ff: got res=%h hi=%h zcnv=%b required res=01 hi=fe zcnv=0111", result, result_hi, flags8);
      end
      @(negedge clk);
      run8(4'd2, 8'h0F, 8'h0F, lat, rh);
      n_checks++;
      if ({result, result_hi} !== {8'h0F, 8'h00}) begin
         n_fail++;
         $display("FAIL hi_cleared_after_mul: got res=%h hi=%h required res=0f hi=00", result, result_hi);
      end
      @(negedge clk);
   endtask

   task automatic test_back_pressure();
      int lat, rh, bad;
      out_ready = 1'b0;
      run8(4'd11, 8'h01, 8'h00, lat, rh);
      n_checks++;
      if ({result, flags8} !== {8'h80, 4'b0110}) begin
         n_fail++;
         $display("FAIL ror_01: got res=%h zcnv=%b required res=80 zcnv=0110", result, flags8);
      end
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         op = 4'd0; a = 8'h10 + 8'(i); b = 8'h20; in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         @(negedge clk);
         if ({out_valid, in_ready, result, flags8} !== {1'b1, 1'b0, 8'h80, 4'b0110}) bad++;
      end
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL hold_stable: got %0d unstable cycles required 0", bad); end
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, result, flags8} !== {1'b1, 1'b0, 8'h80, 4'b0110}) begin
         n_fail++;
         $display("FAIL hold_release: got ready=%b valid=%b res=%h zcnv=%b required ready=1 valid=0 res=80 zcnv=0110",
                  in_ready, out_valid, result, flags8);
      end
   endtask

   task automatic test_reset_mid_mul();
      int lat, rh, bad;
      op = 4'd12; a = 8'h0F; b = 8'h03; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({out_valid, result, result_hi, flags8} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_mul: got ov=%b res=%h hi=%h flags=%b required all zero",
                  out_valid, result, result_hi, flags8);
      end
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) bad++;
      end
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL stale_out_valid: got %0d valid cycles required 0", bad); end
      run8(4'd0, 8'h03, 8'h04, lat, rh);
      n_checks++;
      if ({lat, result} !== {32'd1, 8'h07}) begin
         n_fail++;
         $display("FAIL add_after_reset: got lat=%0d res=%h required lat=1 res=07", lat, result);
      end
      @(negedge clk);
   endtask

   task automatic test_width16();
      int lat;
      run16(4'd0, 16'hFFFF, 16'h0001, lat);
      n_checks++;
      if ({lat, result16, flags16} !== {32'd1, 16'h0000, 4'b1100}) begin
         n_fail++;
         $display("FAIL w16_add: got lat=%0d res=%h zcnv=%b required lat=1 res=0000 zcnv=1100", lat, result16, flags16);
      end
      @(negedge clk);
      run16(4'd12, 16'h0100, 16'h0100, lat);
      n_checks++;
      if (lat !== 17) begin n_fail++; $display("FAIL w16_mul_latency: got %0d required 17", lat); end
      n_checks++;
      if ({result16, result_hi16, flags16} !== {16'h0000, 16'h0001, 4'b0101}) begin
         n_fail++;
         $display("FAIL w16_mul: got res=%h hi=%h zcnv=%b required res=0000 hi=0001 zcnv=0101",
                  result16, result_hi16, flags16);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_add_adc();
      test_sub_cmp();
      test_ops();
      test_mul();
      test_back_pressure();
      test_reset_mid_mul();
      test_width16();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Parameters
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width; legal range 4..32.
REQ-002 SHALL provide parameter MUL_EN, default 1, 1 enables multi-cycle multiply, 0 makes op 12 behave as op 15.

Interface
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operand/op request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 op  input  4  operation select.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  WIDTH  result low word.
REQ-012 result_hi  output  WIDTH  multiply high word, 0 for all other ops.
REQ-013 flag_z, flag_c, flag_n, flag_v  output  1 each  zero, carry/borrow, negative, signed overflow of last completed op.

Function
REQ-014 Op codes: 0 ADD, 1 SUB (a-b), 2 AND, 3 OR, 4 XOR, 5 NOT a, 6 SHL a by 1, 7 SHR a by 1 (logical), 8 ADC (a+b+C), 9 SBB (a-b-C), 10 ROL a by 1, 11 ROR a by 1, 12 MUL unsigned, 13 CMP (flags of a-b, result=a), 14-15 result 0.
REQ-015 SHALL implement FSM states IDLE, MUL, HOLD; in_ready=1 only in IDLE.
REQ-016 Request accepted when in_valid && in_ready on a rising edge; a, b, op, and current C captured at that edge.
REQ-017 Non-MUL op: IDLE -> HOLD on accept; out_valid=1 the following cycle (latency 1).
REQ-018 MUL: IDLE -> MUL on accept; shift-add one bit per cycle for WIDTH cycles; MUL -> HOLD; out_valid asserts exactly WIDTH+1 cycles after accept.
REQ-019 HOLD: result, result_hi, flags stable while out_valid && !out_ready; HOLD -> IDLE when out_ready=1.
REQ-020 No back-to-back overlap: next request is accepted no earlier than the cycle after HOLD exits.
REQ-021 Arithmetic modulo 2^WIDTH; C for ADD/ADC = carry out of bit WIDTH-1; C for SUB/SBB/CMP = borrow (1 when a < b + Cin, unsigned).
REQ-022 V for ADD/ADC/SUB/SBB/CMP = two's-complement signed overflow; V=0 for logic, shift, rotate ops.
REQ-023 C for SHL/ROL = a[WIDTH-1]; SHR/ROR = a[0]; logic ops, NOT and ops 14-15 C=0.
REQ-024 MUL: {result_hi,result} = a*b full 2*WIDTH product; C=V=(result_hi != 0); Z over full product; N=result_hi[WIDTH-1].
REQ-025 Z=(result==0), N=result[WIDTH-1] for all non-MUL ops, including CMP (computed on a-b, not on a).
REQ-026 Flags are registered and retained after HOLD exit until the next result is loaded; ADC/SBB use retained C.
REQ-027 in_valid while not in_ready SHALL be ignored; inputs not sampled.
REQ-028 Operand changes after acceptance SHALL not affect an in-progress MUL.

Reset
REQ-029 rst=1 asynchronously forces IDLE, in_ready=1 after deassert, out_valid=0, result=0, result_hi=0, all flags 0.
REQ-030 rst mid-MUL or in HOLD SHALL discard the operation; no out_valid on the first edge after deassert.
REQ-031 First accept is permitted on the first rising edge after rst deasserts.

Verification (WIDTH=8 unless noted)
REQ-032 ADD a=0xFF b=0x01, out_ready=1 -> one cycle later result=0x00, Z=1, C=1, V=0, N=0; then ADC a=0x00 b=0x00 -> result=0x01, C=0.
REQ-033 SUB a=0x80 b=0x01 -> result=0x7F, V=1, C=0, N=0; CMP a=0x05 b=0x07 -> result=0x05, C=1, N=1, Z=0.
REQ-034 MUL a=0xFF b=0xFF -> out_valid exactly 9 cycles after accept, result=0x01, result_hi=0xFE, C=V=1; in_ready=0 throughout.
REQ-035 Back-pressure: ROR a=0x01 with out_ready=0 for 5 cycles -> result=0x80, C=1 held stable, in_valid pulses ignored; released on out_ready=1, in_ready=1 next cycle.
REQ-036 Assert rst 4 cycles into MUL -> outputs zero immediately, no out_valid after release; new ADD 0x03+0x04 returns 0x07.
REQ-037 WIDTH=16: ADD 0xFFFF+0x0001 -> result=0x0000, Z=1, C=1; MUL 0x0100*0x0100 -> result=0x0000, result_hi=0x0001, out_valid 17 cycles after accept.
